// File: rtl/draw_rect_ctl.sv
// rtl/draw_rect_ctl.sv - per-frame gravity/bounce position controller feeding draw_rect
module draw_rect_ctl #(
    parameter int SCREEN_HEIGHT = 600,
    parameter int RECT_HEIGHT   = 64,
    parameter int GRAVITY       = 1,
    parameter int MAX_VEL       = 63,
    parameter int DAMP_SHIFT    = 1,
    parameter int MIN_VEL       = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        moving
);

    localparam int VW = $clog2(MAX_VEL + 1);
    localparam logic [11:0]   FLOOR_Y = 12'(SCREEN_HEIGHT - RECT_HEIGHT);
    localparam logic [VW-1:0] GRAV_V  = VW'(GRAVITY);
    localparam logic [VW-1:0] MAXV_V  = VW'(MAX_VEL);
    localparam logic [VW-1:0] MINV_V  = VW'(MIN_VEL);

    typedef enum logic [1:0] {IDLE, FALL, RISE, REST} state_t;

    state_t        state_q, state_d;
    logic [11:0]   xpos_q, xpos_d;
    logic [11:0]   ypos_q, ypos_d;
    logic [VW-1:0] vel_q, vel_d;
    logic          vsync_q;
    logic          left_q;

    logic          tick;
    logic          click;
    logic [12:0]   sum;
    logic [VW:0]   vel_inc;
    logic [VW-1:0] damp;
    logic [11:0]   vel_y;

    assign tick    = vsync_in & ~vsync_q;
    assign click   = mouse_left & ~left_q;
    assign vel_y   = 12'(vel_q);
    assign sum     = {1'b0, ypos_q} + {1'b0, vel_y};
    assign vel_inc = {1'b0, vel_q} + {1'b0, GRAV_V};
    assign damp    = vel_q - (vel_q >> DAMP_SHIFT);

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        vel_d   = vel_q;
        case (state_q)
            IDLE: begin
                xpos_d = mouse_xpos;
                ypos_d = (mouse_ypos > FLOOR_Y) ? FLOOR_Y : mouse_ypos;
                if (click) begin
                    state_d = FALL;
                    vel_d   = '0;
                end
            end
            FALL: begin
                if (tick) begin
                    if (sum >= {1'b0, FLOOR_Y}) begin
                        ypos_d = FLOOR_Y;
                        if (damp < MINV_V) begin
                            state_d = REST;
                            vel_d   = '0;
                        end else begin
                            state_d = RISE;
                            vel_d   = damp;
                        end
                    end else begin
                        ypos_d = sum[11:0];
                        vel_d  = (vel_inc > {1'b0, MAXV_V}) ? MAXV_V : vel_inc[VW-1:0];
                    end
                end
            end
            RISE: begin
                if (tick) begin
                    ypos_d = (vel_y > ypos_q) ? 12'd0 : ypos_q - vel_y;
                    if (vel_q <= GRAV_V) begin
                        state_d = FALL;
                        vel_d   = '0;
                    end else begin
                        vel_d = vel_q - GRAV_V;
                    end
                end
            end
            REST: begin
                ypos_d = FLOOR_Y;
                if (click) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q <= IDLE;
            xpos_q  <= '0;
            ypos_q  <= '0;
            vel_q   <= '0;
            vsync_q <= 1'b0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            vel_q   <= vel_d;
            vsync_q <= vsync_in;
            left_q  <= mouse_left;
        end
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign moving = (state_q == FALL) || (state_q == RISE);

endmodule

// File: tb/tb_draw_rect_ctl.sv
// tb/tb_draw_rect_ctl.sv - table-driven and scoreboard bench for draw_rect_ctl
module tb_draw_rect_ctl;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        vsync_in = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        moving;

    draw_rect_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .vsync_in   (vsync_in),
        .mouse_left (mouse_left),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .xpos       (xpos),
        .ypos       (ypos),
        .moving     (moving)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic        rst;
        logic        vs;
        logic        left;
        logic [11:0] mx;
        logic [11:0] my;
        logic        chk;
        logic [11:0] ex;
        logic [11:0] ey;
        logic        emv;
    } vec_t;

    typedef struct packed {
        logic        chk;
        logic [11:0] ex;
        logic [11:0] ey;
        logic        emv;
        int          id;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   checks = 0;
    int   failures = 0;
    int   step = 0;

    task automatic drive(input vec_t v);
        exp_t e;
        rst        = v.rst;
        vsync_in   = v.vs;
        mouse_left = v.left;
        mouse_xpos = v.mx;
        mouse_ypos = v.my;
        e.chk = v.chk;
        e.ex  = v.ex;
        e.ey  = v.ey;
        e.emv = v.emv;
        e.id  = step;
        sb.push_back(e);
        step++;
        @(posedge pclk);
        #1;
        e = sb.pop_front();
        if (e.chk) begin
            checks++;
            if (xpos !== e.ex || ypos !== e.ey || moving !== e.emv) begin
                failures++;
                $display("FAIL step%0d got xpos=%0d ypos=%0d moving=%0b want xpos=%0d ypos=%0d moving=%0b",
                         e.id, xpos, ypos, moving, e.ex, e.ey, e.emv);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic vs, input logic l,
                       input int mx, input int my,
                       input int ex, input int ey, input logic emv);
        vec_t v;
        v.rst = r; v.vs = vs; v.left = l;
        v.mx = 12'(mx); v.my = 12'(my);
        v.chk = 1'b1; v.ex = 12'(ex); v.ey = 12'(ey); v.emv = emv;
        drive(v);
    endtask

    // one frame: vsync high for a cycle then low; position must be identical after both edges
    task automatic tick(input int mx, input int my, input int ex, input int ey, input logic emv);
        cyc(1'b1, 1'b1, 1'b0, mx, my, ex, ey, emv);
        cyc(1'b1, 1'b0, 1'b0, mx, my, ex, ey, emv);
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            tbl[i] = '{1'b0, 1'($urandom), 1'($urandom), 12'($urandom), 12'($urandom),
                       1'b1, 12'd0, 12'd0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 12'd100,  12'd200, 1'b1, 12'd100,  12'd200, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 12'd100,  12'd700, 1'b1, 12'd100,  12'd536, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 12'd7,    12'd536, 1'b1, 12'd7,    12'd536, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 12'd4095, 12'd535, 1'b1, 12'd4095, 12'd535, 1'b0};

        for (int i = 0; i < 8; i++) drive(tbl[i]);

        // drop from the floor: first bounce damps to zero -> REST, then click back to IDLE
        cyc(1'b1, 1'b0, 1'b0, 320, 600, 320, 536, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 321, 600, 321, 536, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 500, 100, 321, 536, 1'b1);
        tick(500, 100, 321, 536, 1'b0);
        tick(500, 100, 321, 536, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 40, 50, 321, 536, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 40, 50, 40, 50, 1'b0);

        // full fall from y=0, bounce, rise to apex
        cyc(1'b1, 1'b0, 1'b0, 300, 0, 300, 0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 300, 0, 300, 0, 1'b1);
        for (int k = 1; k <= 33; k++)
            tick(777, 5, 300, k * (k - 1) / 2, 1'b1);
        tick(777, 5, 300, 536, 1'b1);
        for (int m = 1; m <= 17; m++)
            tick(777, 5, 300, 536 - (17 * m - m * (m - 1) / 2), 1'b1);
        tick(777, 5, 300, 383, 1'b1);
        tick(777, 5, 300, 384, 1'b1);

        // click coinciding with tick mid-fall, then vsync held high
        cyc(1'b1, 1'b1, 1'b1, 777, 5, 300, 386, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 777, 5, 300, 386, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 777, 5, 300, 389, 1'b1);
        for (int j = 0; j < 4; j++)
            cyc(1'b1, 1'b1, 1'b0, 777, 5, 300, 389, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 777, 5, 300, 389, 1'b1);

        // reset pulse mid-fall
        cyc(1'b0, 1'b0, 1'b0, 50, 60, 0, 0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 50, 60, 50, 60, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
